seg7_scan_driver: RTL and testbench

- Time-multiplexed 7-segment display driver.
- Sits directly downstream of the modulo-N counters. Their packed 4-bit digit values are concatenated into digits_in; this block scans them onto a common-anode display.
- Registered outputs throughout. One blanking cycle between digits suppresses ghosting.

---
 rtl/seg7_pkg.sv | 28 ++
 rtl/seg7_decode.sv | 33 +++
 rtl/seg7_scan_driver.sv | 160 ++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared glyph constants and scan-state type for the 7-segment scan driver.
// Glyph bit order is {g,f,e,d,c,b,a}, active low.
package seg7_pkg;

  localparam logic [6:0] SEG_0   = 7'b1000000;
  localparam logic [6:0] SEG_1   = 7'b1111001;
  localparam logic [6:0] SEG_2   = 7'b0100100;
  localparam logic [6:0] SEG_3   = 7'b0110000;
  localparam logic [6:0] SEG_4   = 7'b0011001;
  localparam logic [6:0] SEG_5   = 7'b0010010;
  localparam logic [6:0] SEG_6   = 7'b0000010;
  localparam logic [6:0] SEG_7   = 7'b1111000;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0010000;
  localparam logic [6:0] SEG_A   = 7'b0001000;
  localparam logic [6:0] SEG_B   = 7'b0000011;
  localparam logic [6:0] SEG_C   = 7'b1000110;
  localparam logic [6:0] SEG_D   = 7'b0100001;
  localparam logic [6:0] SEG_E   = 7'b0000110;
  localparam logic [6:0] SEG_F   = 7'b0001110;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble to active-low 7-segment glyph decoder (hex digits
// A-F rendered as A,b,C,d,E,F).
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_n_o
);

  always_comb begin
    seg_n_o = SEG_OFF;
    case (nibble_i)
      4'h0: seg_n_o = SEG_0;
      4'h1: seg_n_o = SEG_1;
      4'h2: seg_n_o = SEG_2;
      4'h3: seg_n_o = SEG_3;
      4'h4: seg_n_o = SEG_4;
      4'h5: seg_n_o = SEG_5;
      4'h6: seg_n_o = SEG_6;
      4'h7: seg_n_o = SEG_7;
      4'h8: seg_n_o = SEG_8;
      4'h9: seg_n_o = SEG_9;
      4'hA: seg_n_o = SEG_A;
      4'hB: seg_n_o = SEG_B;
      4'hC: seg_n_o = SEG_C;
      4'hD: seg_n_o = SEG_D;
      4'hE: seg_n_o = SEG_E;
      4'hF: seg_n_o = SEG_F;
      default: seg_n_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment scan driver with per-frame snapshot
// and a blank cycle between digits. Optional LEADING_ZERO_BLANK_EN blanks leading zeros.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int DIV_WIDTH   = 17,
  parameter int IDX_WIDTH   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic [DIGITS-1:0]     dp_in,
  output logic [6:0]            seg_n,
  output logic                  dp_n,
  output logic [DIGITS-1:0]     an_n,
  output logic                  frame_tick,
  output scan_state_e           state_dbg_o
);

  localparam logic [DIV_WIDTH-1:0] PRESC_LAST = DIV_WIDTH'(REFRESH_DIV - 2);
  localparam logic [IDX_WIDTH-1:0] IDX_LAST   = IDX_WIDTH'(DIGITS - 1);

  scan_state_e            state_q, state_d;
  logic [DIV_WIDTH-1:0]   presc_q, presc_d;
  logic [IDX_WIDTH-1:0]   idx_q, idx_d;
  logic [4*DIGITS-1:0]    snap_digits_q, snap_digits_d;
  logic [DIGITS-1:0]      snap_dp_q, snap_dp_d;
  logic                   tick_pend_q, tick_pend_d;
  logic [6:0]             seg_n_q, seg_n_d;
  logic                   dp_n_q, dp_n_d;
  logic [DIGITS-1:0]      an_n_q, an_n_d;
  logic                   frame_tick_q, frame_tick_d;

  logic [3:0]             cur_nib;
  logic                   cur_dp;
  logic [6:0]             dec_seg_n;
  logic                   blank_glyph;

  // Select the snapshot nibble and dp bit for the digit currently scanned.
  always_comb begin
    cur_nib = 4'h0;
    cur_dp  = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_WIDTH'(i)) begin
        cur_nib = snap_digits_q[4*i +: 4];
        cur_dp  = snap_dp_q[i];
      end
    end
  end

  seg7_decode u_decode (
    .nibble_i (cur_nib),
    .seg_n_o  (dec_seg_n)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] nib_nz;
  logic [DIGITS-1:0] lead_zero;
  logic              cur_lz;

  // lead_zero[i]: nibble i and every nibble above it are zero.
  always_comb begin
    nib_nz    = '0;
    lead_zero = '0;
    cur_lz    = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      nib_nz[i] = |snap_digits_q[4*i +: 4];
    end
    for (int i = 0; i < DIGITS; i++) begin
      lead_zero[i] = ~|(nib_nz >> i);
      if (idx_q == IDX_WIDTH'(i)) begin
        cur_lz = lead_zero[i];
      end
    end
  end

  assign blank_glyph = (idx_q != '0) && cur_lz;
`else
  assign blank_glyph = 1'b0;
`endif

  // Outputs are registered from the current state, so the display lags the
  // FSM by one cycle; frame_tick is delayed via tick_pend_q to stay aligned.
  always_comb begin
    state_d       = state_q;
    presc_d       = presc_q;
    idx_d         = idx_q;
    snap_digits_d = snap_digits_q;
    snap_dp_d     = snap_dp_q;
    tick_pend_d   = tick_pend_q;
    seg_n_d       = SEG_OFF;
    dp_n_d        = 1'b1;
    an_n_d        = '1;
    frame_tick_d  = 1'b0;

    if (en) begin
      frame_tick_d = tick_pend_q;
      tick_pend_d  = 1'b0;
      case (state_q)
        BLANK: begin
          state_d = DRIVE;
          if (idx_q == '0) begin
            snap_digits_d = digits_in;
            snap_dp_d     = dp_in;
            tick_pend_d   = 1'b1;
          end
        end
        DRIVE: begin
          an_n_d  = ~(DIGITS'(1) << idx_q);
          seg_n_d = blank_glyph ? SEG_OFF : dec_seg_n;
          dp_n_d  = ~cur_dp;
          if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_WIDTH'(1);
            state_d = BLANK;
          end else begin
            presc_d = presc_q + DIV_WIDTH'(1);
          end
        end
        default: state_d = BLANK;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= BLANK;
      presc_q       <= '0;
      idx_q         <= '0;
      snap_digits_q <= '0;
      snap_dp_q     <= '0;
      tick_pend_q   <= 1'b0;
      seg_n_q       <= SEG_OFF;
      dp_n_q        <= 1'b1;
      an_n_q        <= '1;
      frame_tick_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      snap_digits_q <= snap_digits_d;
      snap_dp_q     <= snap_dp_d;
      tick_pend_q   <= tick_pend_d;
      seg_n_q       <= seg_n_d;
      dp_n_q        <= dp_n_d;
      an_n_q        <= an_n_d;
      frame_tick_q  <= frame_tick_d;
    end
  end

  assign seg_n       = seg_n_q;
  assign dp_n        = dp_n_q;
  assign an_n        = an_n_q;
  assign frame_tick  = frame_tick_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver with DIGITS=4, REFRESH_DIV=4: per-cycle expected
// display words are queued when stimulus is set up and popped at each negedge.
module tb_seg7_scan_driver;

  localparam int DIGITS      = 4;
  localparam int REFRESH_DIV = 4;
  localparam int DIV_WIDTH   = 2;
  localparam int IDX_WIDTH   = 2;

  // Display word layout: {frame_tick, an_n[3:0], dp_n, seg_n[6:0]}
  localparam logic [12:0] DARK = {1'b0, 4'hF, 1'b1, 7'h7F};

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    en = 1'b0;
  logic [4*DIGITS-1:0]     digits_in = '0;
  logic [DIGITS-1:0]       dp_in = '0;
  logic [6:0]              seg_n;
  logic                    dp_n;
  logic [DIGITS-1:0]       an_n;
  logic                    frame_tick;
  seg7_pkg::scan_state_e   state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  logic [12:0] exp_q[$];

  seg7_scan_driver #(
    .DIGITS      (DIGITS),
    .REFRESH_DIV (REFRESH_DIV),
    .DIV_WIDTH   (DIV_WIDTH),
    .IDX_WIDTH   (IDX_WIDTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .digits_in   (digits_in),
    .dp_in       (dp_in),
    .seg_n       (seg_n),
    .dp_n        (dp_n),
    .an_n        (an_n),
    .frame_tick  (frame_tick),
    .state_dbg_o (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference glyphs and expected words ----------------
  function automatic logic [6:0] glyph(input logic [3:0] nib);
    case (nib)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  // Expected word at offset k (0..15) of a frame, offset 0 = first d0 drive cycle.
  function automatic logic [12:0] frame_word(input logic [15:0] nibs, input logic [3:0] dp, input int k);
    int d;
    logic [6:0] seg;
    logic [3:0] an;
    d = k / 4;
    if ((k % 4) == 3) return DARK;
    seg = glyph(nibs[4*d +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
    if (d > 0 && (nibs >> (4*d)) == 16'h0) seg = 7'h7F;
`endif
    an = 4'hF;
    an[d] = 1'b0;
    return {(d == 0 && k == 0), an, ~dp[d], seg};
  endfunction

  task automatic push_frame(input logic [15:0] nibs, input logic [3:0] dp);
    for (int k = 0; k < 16; k++) exp_q.push_back(frame_word(nibs, dp, k));
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [12:0] obs;
    rst = 1'b1; en = 1'b1; digits_in = 16'h4321; dp_in = 4'b0000;
    repeat (2) @(negedge clk);
    obs = {frame_tick, an_n, dp_n, seg_n};
    n_checks++;
    if (obs !== DARK) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, want %h", obs, DARK);
    end
    n_checks++;
    if (state_dbg !== seg7_pkg::BLANK) begin
      n_fail++;
      $display("FAIL reset_state: got %0d, want %0d", state_dbg, seg7_pkg::BLANK);
    end
    rst = 1'b0;
    @(negedge clk);
    obs = {frame_tick, an_n, dp_n, seg_n};
    n_checks++;
    if (obs !== DARK) begin
      n_fail++;
      $display("FAIL reset_first_blank: got %h, want %h", obs, DARK);
    end
  endtask

  task automatic test_scan();
    logic [12:0] obs, exp;
    push_frame(16'h4321, 4'b0000);
    push_frame(16'h4321, 4'b0000);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      obs = {frame_tick, an_n, dp_n, seg_n};
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 13'hx;
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL scan[%0d]: got tick=%b an_n=%h dp_n=%b seg_n=%h, want tick=%b an_n=%h dp_n=%b seg_n=%h",
                 i, obs[12], obs[11:8], obs[7], obs[6:0], exp[12], exp[11:8], exp[7], exp[6:0]);
      end
    end
  endtask

  task automatic test_tear_free();
    logic [12:0] obs, exp;
    push_frame(16'h4321, 4'b0000);
    push_frame(16'h9876, 4'b0000);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      obs = {frame_tick, an_n, dp_n, seg_n};
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 13'hx;
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL tear_free[%0d]: got tick=%b an_n=%h dp_n=%b seg_n=%h, want tick=%b an_n=%h dp_n=%b seg_n=%h",
                 i, obs[12], obs[11:8], obs[7], obs[6:0], exp[12], exp[11:8], exp[7], exp[6:0]);
      end
      if (i == 9) digits_in = 16'h9876;
    end
  endtask

  task automatic test_enable();
    logic [12:0] obs, exp;
    for (int k = 0; k < 5; k++) exp_q.push_back(frame_word(16'h9876, 4'b0000, k));
    repeat (5) exp_q.push_back(DARK);
    for (int k = 5; k < 16; k++) exp_q.push_back(frame_word(16'h9876, 4'b0000, k));
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      obs = {frame_tick, an_n, dp_n, seg_n};
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 13'hx;
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL enable[%0d]: got tick=%b an_n=%h dp_n=%b seg_n=%h, want tick=%b an_n=%h dp_n=%b seg_n=%h",
                 i, obs[12], obs[11:8], obs[7], obs[6:0], exp[12], exp[11:8], exp[7], exp[6:0]);
      end
      if (i == 4) en = 1'b0;
      if (i == 9) en = 1'b1;
    end
  endtask

  task automatic test_hex_dp();
    logic [12:0] obs, exp;
    push_frame(16'h9876, 4'b0000);
    push_frame(16'hF0A8, 4'b0010);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      obs = {frame_tick, an_n, dp_n, seg_n};
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 13'hx;
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL hex_dp[%0d]: got tick=%b an_n=%h dp_n=%b seg_n=%h, want tick=%b an_n=%h dp_n=%b seg_n=%h",
                 i, obs[12], obs[11:8], obs[7], obs[6:0], exp[12], exp[11:8], exp[7], exp[6:0]);
      end
      if (i == 0) begin
        digits_in = 16'hF0A8;
        dp_in     = 4'b0010;
      end
    end
  endtask

  task automatic test_leading_zero();
    logic [12:0] obs, exp;
    push_frame(16'hF0A8, 4'b0010);
    push_frame(16'h0005, 4'b0100);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      obs = {frame_tick, an_n, dp_n, seg_n};
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 13'hx;
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL leading_zero[%0d]: got tick=%b an_n=%h dp_n=%b seg_n=%h, want tick=%b an_n=%h dp_n=%b seg_n=%h",
                 i, obs[12], obs[11:8], obs[7], obs[6:0], exp[12], exp[11:8], exp[7], exp[6:0]);
      end
      if (i == 0) begin
        digits_in = 16'h0005;
        dp_in     = 4'b0100;
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    logic [12:0] obs, exp;
    for (int k = 0; k < 9; k++) exp_q.push_back(frame_word(16'h0005, 4'b0100, k));
    exp_q.push_back(DARK);
    exp_q.push_back(DARK);
    push_frame(16'h1234, 4'b0000);
    for (int i = 0; i < 27; i++) begin
      @(negedge clk);
      obs = {frame_tick, an_n, dp_n, seg_n};
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 13'hx;
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL reset_mid[%0d]: got tick=%b an_n=%h dp_n=%b seg_n=%h, want tick=%b an_n=%h dp_n=%b seg_n=%h",
                 i, obs[12], obs[11:8], obs[7], obs[6:0], exp[12], exp[11:8], exp[7], exp[6:0]);
      end
      if (i == 8) begin
        rst       = 1'b1;
        digits_in = 16'h1234;
        dp_in     = 4'b0000;
      end
      if (i == 9) rst = 1'b0;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_scan();
    test_tear_free();
    test_enable();
    test_hex_dp();
    test_leading_zero();
    test_reset_mid_scan();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drained: got %0d entries left, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
